// File: rtl/wb_slave_burst_assembler.sv
`default_nettype none
// wb_slave_burst_assembler -- WISHBONE pipelined slave that packs a burst into one NIC packet
// and returns read replies as ACKs, with STALL/RTY back-pressure, reply timeout and CYC abort. Rev 1.0
module wb_slave_burst_assembler #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int MAX_BURST      = 8,
  parameter int N_BITS_BURST   = 3,
  parameter int RETRY_MODE     = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int N_BITS_TIMEOUT = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            CYC_I,
  input  logic                            STB_I,
  input  logic                            WE_I,
  input  logic [2:0]                      CTI_I,
  input  logic [ADDR_WIDTH-1:0]           ADR_I,
  input  logic [DATA_WIDTH-1:0]           DAT_I,
  input  logic [SEL_WIDTH-1:0]            SEL_I,
  output logic [DATA_WIDTH-1:0]           DAT_O,
  output logic                            ACK_O,
  output logic                            ERR_O,
  output logic                            RTY_O,
  output logic                            STALL_O,
  input  logic                            buffer_available_i,
  output logic                            pkt_valid_o,
  input  logic                            pkt_ready_i,
  output logic [MAX_BURST*DATA_WIDTH-1:0] pkt_data_o,
  output logic [ADDR_WIDTH-1:0]           pkt_addr_o,
  output logic [SEL_WIDTH-1:0]            pkt_sel_o,
  output logic                            pkt_we_o,
  output logic [N_BITS_BURST:0]           pkt_len_o,
  output logic                            new_pending_transaction_o,
  input  logic                            reply_valid_i,
  input  logic [DATA_WIDTH-1:0]           reply_data_i,
  input  logic                            reply_last_i
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COLLECT    = 3'd1,
    HANDOFF    = 3'd2,
    WAIT_REPLY = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  localparam logic [N_BITS_BURST:0]     C_MAX_CNT = (N_BITS_BURST+1)'(MAX_BURST);
  localparam logic [N_BITS_BURST:0]     C_ONE     = (N_BITS_BURST+1)'(1);
  localparam logic [N_BITS_TIMEOUT-1:0] C_TO_LAST = N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                    state;
  logic [N_BITS_BURST:0]     beat_cnt;
  logic [N_BITS_TIMEOUT-1:0] to_cnt;
  logic [DATA_WIDTH-1:0]     slots [MAX_BURST];

  logic                      accept;
  logic                      last_beat;
  logic                      timeout_hit;
  logic [N_BITS_BURST:0]     next_cnt;

  always_comb begin
    STALL_O = 1'b0;
    case (state)
      IDLE:    STALL_O = !buffer_available_i && (RETRY_MODE == 0);
      COLLECT: STALL_O = 1'b0;
      default: STALL_O = 1'b1;
    endcase
  end

  // In RTY mode IDLE never stalls, so an unavailable buffer must still block capture here.
  assign accept      = CYC_I && STB_I && !STALL_O &&
                       ((state == IDLE && buffer_available_i) || state == COLLECT);
  assign next_cnt    = (state == IDLE) ? C_ONE : beat_cnt + 1'b1;
  assign last_beat   = (CTI_I == 3'b000) || (CTI_I == 3'b111) || (next_cnt == C_MAX_CNT);
  assign timeout_hit = (to_cnt == C_TO_LAST);

  for (genvar i = 0; i < MAX_BURST; i++) begin : g_pack
    assign pkt_data_o[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state                     <= IDLE;
      beat_cnt                  <= '0;
      to_cnt                    <= '0;
      ACK_O                     <= 1'b0;
      ERR_O                     <= 1'b0;
      RTY_O                     <= 1'b0;
      DAT_O                     <= '0;
      pkt_valid_o               <= 1'b0;
      pkt_addr_o                <= '0;
      pkt_sel_o                 <= '0;
      pkt_we_o                  <= 1'b0;
      pkt_len_o                 <= '0;
      new_pending_transaction_o <= 1'b0;
      for (int i = 0; i < MAX_BURST; i++) slots[i] <= '0;
    end else begin
      ACK_O                     <= 1'b0;
      ERR_O                     <= 1'b0;
      RTY_O                     <= 1'b0;
      DAT_O                     <= '0;
      new_pending_transaction_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pkt_addr_o <= ADR_I;
            pkt_sel_o  <= SEL_I;
            pkt_we_o   <= WE_I;
            slots[0]   <= DAT_I;
            beat_cnt   <= next_cnt;
            ACK_O      <= WE_I;
            if (last_beat) begin
              pkt_len_o   <= next_cnt;
              pkt_valid_o <= 1'b1;
              state       <= HANDOFF;
            end else begin
              state <= COLLECT;
            end
          end else if (CYC_I && STB_I && !buffer_available_i && RETRY_MODE != 0) begin
            RTY_O <= 1'b1;
          end
        end
        COLLECT: begin
          if (!CYC_I) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (accept) begin
            slots[beat_cnt[N_BITS_BURST-1:0]] <= DAT_I;
            beat_cnt <= next_cnt;
            ACK_O    <= pkt_we_o;
            if (last_beat) begin
              pkt_len_o   <= next_cnt;
              pkt_valid_o <= 1'b1;
              state       <= HANDOFF;
            end
          end
        end
        HANDOFF: begin
          if (pkt_ready_i) begin
            pkt_valid_o <= 1'b0;
            beat_cnt    <= '0;
            to_cnt      <= '0;
            if (pkt_we_o) begin
              state <= IDLE;
            end else begin
              new_pending_transaction_o <= 1'b1;
              state                     <= WAIT_REPLY;
            end
          end
        end
        WAIT_REPLY: begin
          if (reply_valid_i) begin
            to_cnt <= '0;
            if (CYC_I) begin
              ACK_O <= 1'b1;
              DAT_O <= reply_data_i;
            end
            if (reply_last_i)  state <= IDLE;
            else if (!CYC_I)   state <= DRAIN;
          end else if (timeout_hit) begin
            to_cnt <= '0;
            ERR_O  <= CYC_I;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (!CYC_I) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (reply_valid_i) begin
            to_cnt <= '0;
            if (reply_last_i) state <= IDLE;
          end else if (timeout_hit) begin
            to_cnt <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_burst_assembler.sv
`default_nettype none
// tb_wb_slave_burst_assembler -- scoreboard bench: stimulus queues expected ACK/RTY/ERR/packet
// events, a negedge monitor pops and compares them. Rev 1.0
module tb_wb_slave_burst_assembler;
  localparam int DW = 32, AW = 32, SW = 4, MB = 8, NB = 3, TO = 16, NT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cyc_i = 0, stb_i = 0, we_i = 0;
  logic [2:0]    cti_i = 0;
  logic [AW-1:0] adr_i = 0;
  logic [DW-1:0] dat_i = 0;
  logic [SW-1:0] sel_i = 0;
  logic          buf_avail = 1, pkt_ready = 0, reply_valid = 0, reply_last = 0;
  logic [DW-1:0] reply_data = 0;

  logic [DW-1:0] dat_o, rm_dat;
  logic ack_o, err_o, rty_o, stall_o, pkt_valid, pkt_we, npt;
  logic rm_ack, rm_err, rm_rty, rm_stall, rm_pkt_valid, rm_pkt_we, rm_npt;
  logic [MB*DW-1:0] pkt_data, rm_pkt_data;
  logic [AW-1:0] pkt_addr, rm_pkt_addr;
  logic [SW-1:0] pkt_sel, rm_pkt_sel;
  logic [NB:0]   pkt_len, rm_pkt_len;

  wb_slave_burst_assembler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .MAX_BURST(MB),
    .N_BITS_BURST(NB), .RETRY_MODE(0), .TIMEOUT_CYCLES(TO), .N_BITS_TIMEOUT(NT)) dut (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .CTI_I(cti_i),
    .ADR_I(adr_i), .DAT_I(dat_i), .SEL_I(sel_i), .DAT_O(dat_o), .ACK_O(ack_o), .ERR_O(err_o),
    .RTY_O(rty_o), .STALL_O(stall_o), .buffer_available_i(buf_avail), .pkt_valid_o(pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(pkt_data), .pkt_addr_o(pkt_addr), .pkt_sel_o(pkt_sel),
    .pkt_we_o(pkt_we), .pkt_len_o(pkt_len), .new_pending_transaction_o(npt),
    .reply_valid_i(reply_valid), .reply_data_i(reply_data), .reply_last_i(reply_last));

  wb_slave_burst_assembler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .MAX_BURST(MB),
    .N_BITS_BURST(NB), .RETRY_MODE(1), .TIMEOUT_CYCLES(TO), .N_BITS_TIMEOUT(NT)) dut_rty (
    .clk(clk), .rst(rst), .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .CTI_I(cti_i),
    .ADR_I(adr_i), .DAT_I(dat_i), .SEL_I(sel_i), .DAT_O(rm_dat), .ACK_O(rm_ack), .ERR_O(rm_err),
    .RTY_O(rm_rty), .STALL_O(rm_stall), .buffer_available_i(buf_avail), .pkt_valid_o(rm_pkt_valid),
    .pkt_ready_i(pkt_ready), .pkt_data_o(rm_pkt_data), .pkt_addr_o(rm_pkt_addr), .pkt_sel_o(rm_pkt_sel),
    .pkt_we_o(rm_pkt_we), .pkt_len_o(rm_pkt_len), .new_pending_transaction_o(rm_npt),
    .reply_valid_i(reply_valid), .reply_data_i(reply_data), .reply_last_i(reply_last));

  typedef struct { logic [DW-1:0] data; int at; } ack_t;
  typedef struct {
    logic [AW-1:0] addr; logic [SW-1:0] sel; logic we; int len;
    logic [MB*DW-1:0] d; int at; int vlen;
  } pkt_t;

  ack_t exp_ack[$];
  pkt_t exp_pkt[$];
  int   exp_err[$], exp_rty[$], exp_npt[$];
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  pkt_t cur;
  ack_t a_m;
  bit   have_cur = 0;
  int   vrun = 0, t_m;
  always @(negedge clk) begin
    chk("rty_in_stall_mode", rty_o, 0);
    if (ack_o) begin
      chk("ack_expected", exp_ack.size() != 0, 1);
      if (exp_ack.size() != 0) begin
        a_m = exp_ack.pop_front();
        chk("ack_dat", dat_o, a_m.data);
        chk("ack_cycle", cyc, a_m.at);
      end
    end
    if (rm_rty) begin
      chk("rty_expected", exp_rty.size() != 0, 1);
      if (exp_rty.size() != 0) begin t_m = exp_rty.pop_front(); chk("rty_cycle", cyc, t_m); end
    end
    if (err_o) begin
      chk("err_expected", exp_err.size() != 0, 1);
      if (exp_err.size() != 0) begin t_m = exp_err.pop_front(); chk("err_cycle", cyc, t_m); end
    end
    if (npt) begin
      chk("npt_expected", exp_npt.size() != 0, 1);
      if (exp_npt.size() != 0) begin t_m = exp_npt.pop_front(); chk("npt_cycle", cyc, t_m); end
    end
    if (pkt_valid) begin
      if (!have_cur) begin
        chk("pkt_expected", exp_pkt.size() != 0, 1);
        if (exp_pkt.size() != 0) begin
          cur = exp_pkt.pop_front(); have_cur = 1; vrun = 0;
          chk("pkt_start_cycle", cyc, cur.at);
        end
      end
      if (have_cur) begin
        vrun++;
        chk("pkt_addr", pkt_addr, cur.addr);
        chk("pkt_sel", pkt_sel, cur.sel);
        chk("pkt_we", pkt_we, cur.we);
        chk("pkt_len", pkt_len, cur.len);
        for (int i = 0; i < MB; i++)
          if (i < cur.len) chk("pkt_slot", pkt_data[i*DW +: DW], cur.d[i*DW +: DW]);
      end
      chk("pkt_len_nonzero", pkt_len != 0, 1);
      chk("stall_in_handoff", stall_o, 1);
    end else if (have_cur) begin
      chk("pkt_valid_cycles", vrun, cur.vlen);
      have_cur = 0;
    end
    // With the buffer available, the RTY-mode instance must behave identically.
    chk("retry_mode_mirror", {rm_ack, rm_err, rm_npt, rm_pkt_valid, rm_pkt_we, rm_pkt_len, rm_dat},
        {ack_o, err_o, npt, pkt_valid, pkt_we, pkt_len, dat_o});
    chk("retry_mode_mirror_pkt",
        (rm_pkt_data == pkt_data) && (rm_pkt_addr == pkt_addr) && (rm_pkt_sel == pkt_sel), 1);
  end

  logic [DW-1:0] bdata [MB];
  logic [DW-1:0] rdata [MB];
  int rgap_fixed = -1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    cyc_i = 0; stb_i = 0; we_i = 0; cti_i = 3'b000;
  endtask

  // mode: 0 normal, 1 read timeout, 2 read with CYC drop in WAIT_REPLY,
  //       3 write aborted after 2 beats, 4 reset during HANDOFF
  task automatic xfer(input bit we, input int len, input int d, input int mode, input logic [2:0] last_cti);
    pkt_t p;
    ack_t a;
    int   hs, gap;
    p.addr = $urandom; p.sel = SW'($urandom); p.we = we; p.len = len; p.d = '0;
    p.vlen = (mode == 4) ? 2 : d + 1;
    for (int i = 0; i < len; i++) p.d[i*DW +: DW] = bdata[i];
    for (int i = 0; i < len; i++) begin
      if (mode == 3 && i == 2) begin idle_bus(); tick(); return; end
      cyc_i = 1; stb_i = 1;
      we_i  = (i == 0) ? we : 1'($urandom);
      adr_i = (i == 0) ? p.addr : $urandom;
      sel_i = (i == 0) ? p.sel : SW'($urandom);
      dat_i = bdata[i];
      cti_i = (i == len - 1 && len < MB) ? last_cti : 3'b010;
      if (we) begin a.data = '0; a.at = cyc + 1; exp_ack.push_back(a); end
      tick();
    end
    p.at = cyc;
    exp_pkt.push_back(p);
    stb_i = 0;
    if (we) cyc_i = 1'($urandom);
    if (mode == 4) begin
      idle_bus(); pkt_ready = 0;
      tick(); rst = 0; tick();
      @(negedge clk);
      chk("rst_outputs", {ack_o, err_o, rty_o, stall_o, pkt_valid, pkt_we, npt, pkt_len}, 0);
      chk("rst_dat_addr", {dat_o, pkt_addr, pkt_sel}, 0);
      chk("rst_pkt_data", pkt_data == 0, 1);
      rst = 1;
      tick();
      return;
    end
    pkt_ready = 0;
    repeat (d) tick();
    pkt_ready = 1; tick(); pkt_ready = 0;
    hs = cyc;
    if (!we) begin
      exp_npt.push_back(hs);
      if (mode == 0) begin
        for (int j = 0; j < len; j++) begin
          gap = (rgap_fixed >= 0) ? rgap_fixed : $urandom_range(0, 2);
          repeat (gap) tick();
          reply_valid = 1; reply_data = rdata[j]; reply_last = (j == len - 1);
          a.data = rdata[j]; a.at = cyc + 1; exp_ack.push_back(a);
          tick();
          reply_valid = 0; reply_last = 0;
        end
      end else if (mode == 1) begin
        exp_err.push_back(hs + TO);
        repeat (TO) tick();
      end else if (mode == 2) begin
        reply_valid = 1; reply_data = rdata[0]; reply_last = 0;
        a.data = rdata[0]; a.at = cyc + 1; exp_ack.push_back(a);
        tick();
        reply_valid = 0; cyc_i = 0;
        tick();
        for (int j = 0; j < 3; j++) begin
          reply_valid = 1; reply_data = $urandom; reply_last = (j == 2);
          tick();
          reply_valid = 0; reply_last = 0;
          tick();
        end
      end
    end
    idle_bus();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ack_o, err_o, rty_o, stall_o, pkt_valid, pkt_we, npt, pkt_len}, 0);
    chk("reset_dat", {dat_o, pkt_addr}, 0);
    rst = 1;
    tick();

    // Classic single write
    bdata[0] = 32'hDEADBEEF;
    xfer(1, 1, 0, 0, 3'b000);

    // 8-beat incrementing write, closed by beat count, ready held low 5 cycles
    for (int i = 0; i < MB; i++) bdata[i] = i;
    xfer(1, 8, 5, 0, 3'b010);

    // 4-beat read, replies 0xA0..0xA3 with 2 idle cycles between
    for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; rdata[i] = 32'hA0 + i; end
    rgap_fixed = 2;
    xfer(0, 4, 1, 0, 3'b111);
    rgap_fixed = -1;

    // Read with no reply: ERR_O, then a new cycle is accepted
    xfer(0, 1, 0, 1, 3'b000);
    bdata[0] = $urandom;
    xfer(1, 1, 0, 0, 3'b111);

    // No buffer: single strobe -> RTY on the RTY-mode instance, STALL on the other
    buf_avail = 0; cyc_i = 1; stb_i = 1; we_i = 1; cti_i = 3'b000;
    adr_i = $urandom; dat_i = $urandom; sel_i = 4'hF;
    exp_rty.push_back(cyc + 1);
    @(negedge clk);
    chk("stall_busy", stall_o, 1);
    chk("rty_mode_no_stall", rm_stall, 0);
    tick();
    idle_bus();
    tick();
    cyc_i = 1; stb_i = 1;
    for (int i = 0; i < 3; i++) begin
      exp_rty.push_back(cyc + 1);
      @(negedge clk);
      chk("stall_busy_hold", stall_o, 1);
      tick();
    end
    buf_avail = 1;
    @(negedge clk);
    chk("stall_released", stall_o, 0);
    bdata[0] = $urandom;
    xfer(1, 1, 0, 0, 3'b000);

    // CYC_I drops after 2 of 4 write beats
    for (int i = 0; i < 4; i++) bdata[i] = $urandom;
    xfer(1, 4, 0, 3, 3'b111);
    tick();

    // CYC_I drops in WAIT_REPLY with 3 replies pending, then DRAIN exits on reply_last
    for (int i = 0; i < 4; i++) begin bdata[i] = $urandom; rdata[i] = $urandom; end
    xfer(0, 4, 0, 2, 3'b111);
    bdata[0] = $urandom;
    xfer(1, 1, 0, 0, 3'b000);

    // Reset during HANDOFF
    bdata[0] = $urandom; bdata[1] = $urandom;
    xfer(1, 2, 0, 4, 3'b111);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      automatic bit w = 1'($urandom);
      automatic int l = $urandom_range(1, MB);
      automatic int m = (!w && $urandom_range(0, 9) == 0) ? 1 : 0;
      for (int i = 0; i < MB; i++) begin bdata[i] = $urandom; rdata[i] = $urandom; end
      xfer(w, l, $urandom_range(0, 3), m, $urandom_range(0, 1) != 0 ? 3'b111 : 3'b000);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (5) tick();
    chk("leftover_ack", exp_ack.size(), 0);
    chk("leftover_pkt", exp_pkt.size(), 0);
    chk("leftover_err", exp_err.size(), 0);
    chk("leftover_rty", exp_rty.size(), 0);
    chk("leftover_npt", exp_npt.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
